// File: rtl/dds_tune_ctrl.sv
// Front-panel tuning controller: turns debounced UP/DOWN/CENTER levels into saturating,
// accelerating hold-to-repeat divider updates and schedules display-convert requests.
module dds_tune_ctrl #(
   parameter int unsigned      DIV_W         = 16,
   parameter logic [DIV_W-1:0] DIV_MIN       = 16'd1,
   parameter logic [DIV_W-1:0] DIV_MAX       = 16'hFFFF,
   parameter logic [DIV_W-1:0] DIV_PRESET    = 16'd1000,
   parameter int unsigned      REPEAT_DELAY  = 25000000,
   parameter int unsigned      REPEAT_PERIOD = 2500000,
   parameter int unsigned      ACCEL_REPEATS = 8,
   parameter int unsigned      STEP_MAX_LOG2 = 8
) (
   input  logic             sys_clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             btn_up,
   input  logic             btn_dn,
   input  logic             btn_ct,
   input  logic             disp_busy,
   output logic [DIV_W-1:0] divider,
   output logic             disp_req,
   output logic             led_r,
   output logic             led_g
);

   localparam int unsigned CNT_TOP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned CNT_W   = $clog2(CNT_TOP + 1);
   localparam int unsigned REP_W   = $clog2(ACCEL_REPEATS + 1);
   localparam int unsigned LOG_W   = $clog2(STEP_MAX_LOG2 + 1);

   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [REP_W-1:0] REP_LAST    = REP_W'(ACCEL_REPEATS - 1);
   localparam logic [LOG_W-1:0] LOG_MAX     = LOG_W'(STEP_MAX_LOG2);

   typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, REPEAT = 2'd2} state_t;

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [REP_W-1:0] rep_r;
   logic [LOG_W-1:0] log2_r;
   logic             dir_up_r;
   logic             up_q_r, dn_q_r, ct_q_r;
   logic             dirty_r;

   logic             ct_rise_s, up_tap_s, dn_tap_s, abort_s;
   logic             do_step_s, step_up_s, changed_s, fire_s;
   logic [DIV_W:0]   step_s, sum_s, floor_s;
   logic [DIV_W-1:0] up_val_s, dn_val_s, next_div_s;

   // Decode button events, pick the step and compute the clamped candidate divider
   always_comb begin
      ct_rise_s = en & btn_ct & ~ct_q_r;
      up_tap_s  = en & ~btn_ct & btn_up & ~btn_dn & ~up_q_r;
      dn_tap_s  = en & ~btn_ct & btn_dn & ~btn_up & ~dn_q_r;
      abort_s   = ~en | btn_ct | (btn_up & btn_dn) | (dir_up_r ? ~btn_up : ~btn_dn);
      // A fresh tap always moves by one, whatever the acceleration state
      step_s    = (state_r == IDLE) ? (DIV_W+1)'(1) : ((DIV_W+1)'(1) << log2_r);
      sum_s     = {1'b0, divider} + step_s;
      floor_s   = {1'b0, DIV_MIN} + step_s;
      up_val_s  = (sum_s > {1'b0, DIV_MAX}) ? DIV_MAX : sum_s[DIV_W-1:0];
      dn_val_s  = ({1'b0, divider} < floor_s) ? DIV_MIN : (divider - step_s[DIV_W-1:0]);
      do_step_s = 1'b0;
      step_up_s = dir_up_r;
      case (state_r)
         IDLE: begin
            do_step_s = up_tap_s | dn_tap_s;
            step_up_s = up_tap_s;
         end
         HOLD:    do_step_s = ~abort_s & (cnt_r == DELAY_LAST);
         REPEAT:  do_step_s = ~abort_s & (cnt_r == PERIOD_LAST);
         default: do_step_s = 1'b0;
      endcase
      next_div_s = step_up_s ? up_val_s : dn_val_s;
      changed_s  = do_step_s & (next_div_s != divider);
      fire_s     = dirty_r & ~disp_busy & ~disp_req;
   end

   // Divider, LEDs, display handshake and the hold/repeat FSM
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         rep_r    <= '0;
         log2_r   <= '0;
         dir_up_r <= 1'b0;
         up_q_r   <= 1'b0;
         dn_q_r   <= 1'b0;
         ct_q_r   <= 1'b0;
         dirty_r  <= 1'b1;
         divider  <= DIV_PRESET;
         disp_req <= 1'b0;
         led_r    <= 1'b0;
         led_g    <= 1'b0;
      end else begin
         up_q_r   <= btn_up;
         dn_q_r   <= btn_dn;
         ct_q_r   <= btn_ct;
         disp_req <= fire_s;
         // A change in the request cycle must survive so it gets its own request
         dirty_r  <= changed_s | ct_rise_s | (dirty_r & ~fire_s);
         if (ct_rise_s) begin
            divider <= DIV_PRESET;
            led_r   <= 1'b0;
            led_g   <= 1'b0;
         end else if (changed_s) begin
            divider <= next_div_s;
            if (step_up_s) begin
               led_g <= ~led_g;
               led_r <= 1'b0;
            end else begin
               led_r <= ~led_r;
               led_g <= 1'b0;
            end
         end else begin
            divider <= divider;
         end
         case (state_r)
            IDLE: begin
               cnt_r  <= '0;
               rep_r  <= '0;
               log2_r <= '0;
               if (up_tap_s | dn_tap_s) begin
                  state_r  <= HOLD;
                  dir_up_r <= up_tap_s;
               end else begin
                  state_r <= IDLE;
               end
            end
            HOLD: begin
               if (abort_s) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
                  rep_r   <= '0;
                  log2_r  <= '0;
               end else if (cnt_r == DELAY_LAST) begin
                  state_r <= REPEAT;
                  cnt_r   <= '0;
                  rep_r   <= REP_W'(1);
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            REPEAT: begin
               if (abort_s) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
                  rep_r   <= '0;
                  log2_r  <= '0;
               end else if (cnt_r == PERIOD_LAST) begin
                  cnt_r <= '0;
                  if (rep_r == REP_LAST) begin
                     rep_r  <= '0;
                     log2_r <= (log2_r == LOG_MAX) ? log2_r : (log2_r + LOG_W'(1));
                  end else begin
                     rep_r <= rep_r + REP_W'(1);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
               rep_r   <= '0;
               log2_r  <= '0;
            end
         endcase
      end
   end

endmodule
